// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and counter sizing for the piso_tx serial transmitter.
package piso_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
  localparam int CNT_W = cnt_w(4);
endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: frame bit counter with clear, saturating increment and last-bit flag.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);
  localparam int CW = cnt_w(WIDTH);
  logic [CW-1:0] cnt;
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !last) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/piso_tx.sv
// piso_tx: valid/ready parallel-in serial-out transmitter, LSB first, one bit per clk.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);
  state_t state;
  logic [WIDTH-1:0] shreg;
  logic shifting, cnt_last, accept;
  assign shifting   = state == SHIFT;
  assign sout_valid = state != IDLE;
  assign load_ready = state == IDLE || done;
  assign accept     = load_valid && load_ready;
`ifdef PISO_PARITY_EN
  logic par;
  assign done = state == PARITY;
  assign sout = state == PARITY ? par : shifting && shreg[0];
`else
  assign done = shifting && cnt_last;
  assign sout = shifting && shreg[0];
`endif
  // Counter restarts on every accept so back-to-back frames begin at bit 0.
  piso_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept || (shifting && cnt_last)),
    .inc  (shifting),
    .last (cnt_last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
`ifdef PISO_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (accept) begin
      state <= SHIFT;
      shreg <= data_in;
`ifdef PISO_PARITY_EN
      par   <= ^data_in;
`endif
    end else if (shifting) begin
      shreg <= shreg >> 1;
`ifdef PISO_PARITY_EN
      if (cnt_last) state <= PARITY;
`else
      if (cnt_last) state <= IDLE;
`endif
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed checks of piso_tx with a paired SIPO receiver model.
module tb_piso_tx;
  logic clk = 1'b0;
  logic rst_n, load_valid, load_ready, sout, sout_valid, done;
  logic [3:0] data_in, rx;
  int passed = 0, total = 0;

  piso_tx #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .data_in(data_in), .sout(sout), .sout_valid(sout_valid), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sout_valid) rx <= {sout, rx[3:1]};

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic test_reset;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({sout, sout_valid, load_ready, done} !== 4'b0010)
        $display("FAIL reset idle cyc %0d: sout/valid/ready/done=%b want 0010", i, {sout, sout_valid, load_ready, done});
      else passed++;
    end
  endtask

  task automatic send_frame(input logic [3:0] w);
    @(negedge clk);
    load_valid = 1'b1;
    data_in = w;
    @(posedge clk);
    #1 load_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({sout_valid, sout, done} !== {1'b1, w[k], k == 3})
        $display("FAIL frame %h bit %0d: valid/sout/done=%b want %b", w, k, {sout_valid, sout, done}, {1'b1, w[k], k == 3});
      else passed++;
    end
    @(posedge clk);
    total++;
    if (rx !== w) $display("FAIL rx word: got %h want %h", rx, w);
    else passed++;
  endtask

  task automatic test_single;
    send_frame(4'b1011);
    @(negedge clk);
    total++;
    if ({sout, sout_valid, done} !== 3'b000)
      $display("FAIL post-frame idle: sout/valid/done=%b want 000", {sout, sout_valid, done});
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq;
    seq = 8'h5A;
    @(negedge clk);
    load_valid = 1'b1;
    data_in = 4'hA;
    @(posedge clk);
    #1 data_in = 4'h5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if ({sout_valid, sout, load_ready, done} !== {1'b1, seq[k], k == 3 || k == 7, k == 3 || k == 7})
        $display("FAIL b2b bit %0d: valid/sout/ready/done=%b want %b", k, {sout_valid, sout, load_ready, done},
                 {1'b1, seq[k], k == 3 || k == 7, k == 3 || k == 7});
      else passed++;
      if (k == 7) load_valid = 1'b0;
    end
    @(negedge clk);
    total++;
    if (sout_valid !== 1'b0) $display("FAIL b2b gap after: sout_valid=%b want 0", sout_valid);
    else passed++;
  endtask

  task automatic test_ignore_busy;
    logic [3:0] w;
    w = 4'h3;
    @(negedge clk);
    load_valid = 1'b1;
    data_in = w;
    @(posedge clk);
    #1 load_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        load_valid = 1'b1;
        data_in = 4'hF;
        total++;
        if (load_ready !== 1'b0) $display("FAIL busy ready: got %b want 0", load_ready);
        else passed++;
      end
      if (k == 2) load_valid = 1'b0;
      total++;
      if (sout !== w[k]) $display("FAIL busy bit %0d: sout=%b want %b", k, sout, w[k]);
      else passed++;
    end
    @(negedge clk);
    total++;
    if (sout_valid !== 1'b0) $display("FAIL busy pulse accepted: sout_valid=%b want 0", sout_valid);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [3:0] w;
    w = 4'h6;
    @(negedge clk);
    load_valid = 1'b1;
    data_in = w;
    @(posedge clk);
    #1 load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (sout !== w[k]) $display("FAIL mid bit %0d: sout=%b want %b", k, sout, w[k]);
      else passed++;
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({sout, sout_valid, done} !== 3'b000)
      $display("FAIL mid reset outputs: sout/valid/done=%b want 000", {sout, sout_valid, done});
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({sout_valid, load_ready} !== 2'b01)
        $display("FAIL after release %0d: valid/ready=%b want 01", i, {sout_valid, load_ready});
      else passed++;
    end
    send_frame(4'h9);
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity(input logic [3:0] w, input logic p);
    logic [4:0] f;
    f = {p, w};
    @(negedge clk);
    load_valid = 1'b1;
    data_in = w;
    @(posedge clk);
    #1 load_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({sout_valid, sout, done} !== {1'b1, f[k], k == 4})
        $display("FAIL parity %h bit %0d: valid/sout/done=%b want %b", w, k, {sout_valid, sout, done}, {1'b1, f[k], k == 4});
      else passed++;
    end
    @(negedge clk);
    total++;
    if (sout_valid !== 1'b0) $display("FAIL parity idle: sout_valid=%b want 0", sout_valid);
    else passed++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    data_in = 4'h0;
    rx = 4'h0;
    repeat (3) @(posedge clk);
    test_reset;
`ifdef PISO_PARITY_EN
    test_parity(4'b1011, 1'b1);
    test_parity(4'b0011, 1'b0);
`else
    test_single;
    test_back_to_back;
    test_ignore_busy;
    test_reset_mid;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
